// File: rtl/periph_reg_demux_if.sv
// Register-bus bundle between the upstream AXI-to-reg bridge and the
// downstream register slaves of periph_reg_demux.
//   in_*  : single upstream request/response channel
//   out_* : shared downstream request fields, one-hot valid, per-slave responses
// Modports: slave = demux view, master = bridge/slave-model view.
interface periph_reg_demux_if #(
    parameter int unsigned NumSlaves = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    // upstream request
    logic                           in_valid_i;
    logic                           in_write_i;
    logic [AddrWidth-1:0]           in_addr_i;
    logic [DataWidth-1:0]           in_wdata_i;
    logic [StrbWidth-1:0]           in_wstrb_i;
    // upstream response
    logic                           in_ready_o;
    logic [DataWidth-1:0]           in_rdata_o;
    logic                           in_error_o;
    // downstream request
    logic [NumSlaves-1:0]           out_valid_o;
    logic                           out_write_o;
    logic [AddrWidth-1:0]           out_addr_o;
    logic [DataWidth-1:0]           out_wdata_o;
    logic [StrbWidth-1:0]           out_wstrb_o;
    // downstream responses
    logic [NumSlaves-1:0]           out_ready_i;
    logic [NumSlaves*DataWidth-1:0] out_rdata_i;
    logic [NumSlaves-1:0]           out_error_i;

    modport slave (
        input  in_valid_i, in_write_i, in_addr_i, in_wdata_i, in_wstrb_i,
        input  out_ready_i, out_rdata_i, out_error_i,
        output in_ready_o, in_rdata_o, in_error_o,
        output out_valid_o, out_write_o, out_addr_o, out_wdata_o, out_wstrb_o
    );

    modport master (
        output in_valid_i, in_write_i, in_addr_i, in_wdata_i, in_wstrb_i,
        output out_ready_i, out_rdata_i, out_error_i,
        input  in_ready_o, in_rdata_o, in_error_o,
        input  out_valid_o, out_write_o, out_addr_o, out_wdata_o, out_wstrb_o
    );
endinterface

// File: rtl/periph_reg_demux.sv
// Rule-driven register-interface demultiplexer. Each upstream request is
// latched, decoded against NumSlaves [start, end) address rules (lowest index
// wins, end <= start disables a rule) and forwarded to exactly one slave.
// Unmapped addresses get an error response with rdata 0xBADCAB1E.
//
// Ports:
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   bus (slave)      : upstream in_* channel and downstream out_* channels
//   busy_o           : FSM is not idle
//   err_count_o      : saturating count of decode (and timeout) errors
//   last_err_addr_o  : address of the most recent counted error
//
// Optional feature: define PERIPH_REG_DEMUX_TIMEOUT_EN to bound the time spent
// waiting on a slave to TimeoutCycles cycles; otherwise FWD waits indefinitely.
module periph_reg_demux #(
    parameter int unsigned NumSlaves = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 32,
    parameter logic [NumSlaves*AddrWidth-1:0] RuleStart =
        {64'h14000, 64'h13000, 64'h12000, 64'h11000},
    parameter logic [NumSlaves*AddrWidth-1:0] RuleEnd =
        {64'h15000, 64'h14000, 64'h13000, 64'h12000}
`ifdef PERIPH_REG_DEMUX_TIMEOUT_EN
    ,
    parameter int unsigned TimeoutCycles = 256
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    periph_reg_demux_if.slave    bus,
    output logic                 busy_o,
    output logic [15:0]          err_count_o,
    output logic [AddrWidth-1:0] last_err_addr_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned IdxWidth  = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
    localparam logic [31:0] BadData   = 32'hBADCAB1E;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        ERR,
        RESP
    } state_e;

    state_e                 state;
    logic                   lat_write;
    logic [AddrWidth-1:0]   lat_addr;
    logic [DataWidth-1:0]   lat_wdata;
    logic [StrbWidth-1:0]   lat_wstrb;
    logic [IdxWidth-1:0]    lat_idx;
    logic [NumSlaves-1:0]   out_valid;
    logic                   in_ready;
    logic [DataWidth-1:0]   in_rdata;
    logic                   in_error;
    logic                   busy;
    logic [15:0]            err_count;
    logic [AddrWidth-1:0]   last_err_addr;

    // Per-rule address match on the live upstream address
    logic [NumSlaves-1:0]   rule_hit;
    logic [DataWidth-1:0]   slv_rdata [NumSlaves];

    for (genvar g = 0; g < NumSlaves; g++) begin : g_rule
        localparam logic [AddrWidth-1:0] Start = RuleStart[g*AddrWidth +: AddrWidth];
        localparam logic [AddrWidth-1:0] End   = RuleEnd[g*AddrWidth +: AddrWidth];
        localparam bit                   Enable = (End > Start);

        assign rule_hit[g]  = Enable && (bus.in_addr_i >= Start) && (bus.in_addr_i < End);
        assign slv_rdata[g] = bus.out_rdata_i[g*DataWidth +: DataWidth];
    end

    // Priority encode: iterate downward so the lowest matching index is kept
    logic                   dec_hit;
    logic [IdxWidth-1:0]    dec_idx;
    logic [NumSlaves-1:0]   dec_onehot;

    always_comb begin
        dec_hit    = |rule_hit;
        dec_idx    = '0;
        dec_onehot = '0;
        for (int i = int'(NumSlaves) - 1; i >= 0; i--) begin
            if (rule_hit[i]) begin
                dec_idx = IdxWidth'(i);
            end
        end
        for (int i = 0; i < int'(NumSlaves); i++) begin
            dec_onehot[i] = dec_hit && (dec_idx == IdxWidth'(i));
        end
    end

    // Response of the latched slave; other ports are never looked at
    logic                   sel_ready;
    logic                   sel_error;
    logic [DataWidth-1:0]   sel_rdata;

    assign sel_ready = bus.out_ready_i[lat_idx];
    assign sel_error = bus.out_error_i[lat_idx];
    assign sel_rdata = slv_rdata[lat_idx];

    // Timeout: counter is zero outside FWD, so it restarts on every FWD entry
    logic timeout_c;

`ifdef PERIPH_REG_DEMUX_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

    logic [CntWidth-1:0] fwd_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fwd_cnt <= '0;
        end else if (state != FWD) begin
            fwd_cnt <= '0;
        end else begin
            fwd_cnt <= fwd_cnt + CntWidth'(1);
        end
    end

    // High during the TimeoutCycles-th FWD cycle; a ready in that cycle still wins
    assign timeout_c = (fwd_cnt == CntWidth'(TimeoutCycles - 1));
`else
    assign timeout_c = 1'b0;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Transaction FSM with registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            lat_write     <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            lat_wstrb     <= '0;
            lat_idx       <= '0;
            out_valid     <= '0;
            in_ready      <= 1'b0;
            in_rdata      <= '0;
            in_error      <= 1'b0;
            busy          <= 1'b0;
            err_count     <= '0;
            last_err_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        lat_write <= bus.in_write_i;
                        lat_addr  <= bus.in_addr_i;
                        lat_wdata <= bus.in_wdata_i;
                        lat_wstrb <= bus.in_wstrb_i;
                        lat_idx   <= dec_idx;
                        busy      <= 1'b1;
                        out_valid <= dec_onehot;
                        state     <= dec_hit ? FWD : ERR;
                    end
                end
                FWD: begin
                    if (sel_ready) begin
                        in_rdata  <= sel_rdata;
                        in_error  <= sel_error;
                        in_ready  <= 1'b1;
                        out_valid <= '0;
                        state     <= RESP;
                    end else if (timeout_c) begin
                        in_rdata      <= DataWidth'(BadData);
                        in_error      <= 1'b1;
                        in_ready      <= 1'b1;
                        out_valid     <= '0;
                        err_count     <= sat_inc(err_count);
                        last_err_addr <= lat_addr;
                        state         <= RESP;
                    end
                end
                ERR: begin
                    in_rdata      <= DataWidth'(BadData);
                    in_error      <= 1'b1;
                    in_ready      <= 1'b1;
                    err_count     <= sat_inc(err_count);
                    last_err_addr <= lat_addr;
                    state         <= RESP;
                end
                RESP: begin
                    in_ready <= 1'b0;
                    in_rdata <= '0;
                    in_error <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    out_valid <= '0;
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready_o   = in_ready;
    assign bus.in_rdata_o   = in_rdata;
    assign bus.in_error_o   = in_error;
    assign bus.out_valid_o  = out_valid;
    assign bus.out_write_o  = lat_write;
    assign bus.out_addr_o   = lat_addr;
    assign bus.out_wdata_o  = lat_wdata;
    assign bus.out_wstrb_o  = lat_wstrb;
    assign busy_o           = busy;
    assign err_count_o      = err_count;
    assign last_err_addr_o  = last_err_addr;

endmodule

// File: tb/tb_periph_reg_demux.sv
// Scoreboard bench for periph_reg_demux: expected responses are queued when a
// request is driven and popped when the upstream response appears. A second
// instance with overlapping and disabled rules covers decode priority.
module tb_periph_reg_demux;
    localparam int unsigned NS = 4;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam logic [DW-1:0] BAD = 32'hBADCAB1E;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    periph_reg_demux_if #(.NumSlaves(NS), .AddrWidth(AW), .DataWidth(DW)) bus ();
    periph_reg_demux_if #(.NumSlaves(NS), .AddrWidth(AW), .DataWidth(DW)) bus2 ();

    logic          busy, busy2;
    logic [15:0]   ec, ec2;
    logic [AW-1:0] lea, lea2;

    periph_reg_demux #(
        .NumSlaves(NS), .AddrWidth(AW), .DataWidth(DW)
`ifdef PERIPH_REG_DEMUX_TIMEOUT_EN
        , .TimeoutCycles(8)
`endif
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus),
        .busy_o(busy), .err_count_o(ec), .last_err_addr_o(lea)
    );

    // slave0 [0x11000,0x13000), slave1 [0x12000,0x13000), slave2 disabled
    periph_reg_demux #(
        .NumSlaves(NS), .AddrWidth(AW), .DataWidth(DW),
        .RuleStart({64'h40000, 64'h30000, 64'h12000, 64'h11000}),
        .RuleEnd  ({64'h41000, 64'h30000, 64'h13000, 64'h13000})
`ifdef PERIPH_REG_DEMUX_TIMEOUT_EN
        , .TimeoutCycles(8)
`endif
    ) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus2),
        .busy_o(busy2), .err_count_o(ec2), .last_err_addr_o(lea2)
    );

    typedef struct {
        int            lat;
        logic [NS-1:0] vmask;
        int            vcycles;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_errs = 0;

    int            obs_lat;
    int            obs_vcycles;
    logic [NS-1:0] obs_vmask;
    logic [DW-1:0] obs_rdata;
    logic          obs_err;
    bit            obs_fields_ok;
    bit            obs_busy_ok;
    bit            obs_pulse_ok;

    // Selected port answers as told; every other port shouts a bogus response
    task automatic drive_slaves(input int sel, input bit rdy, input logic [DW-1:0] rd, input logic er);
        for (int i = 0; i < int'(NS); i++) begin
            if (i == sel) begin
                bus.out_ready_i[i]           = rdy;
                bus.out_rdata_i[i*DW +: DW]  = rdy ? rd : '0;
                bus.out_error_i[i]           = rdy ? er : 1'b0;
            end else begin
                bus.out_ready_i[i]           = 1'b1;
                bus.out_rdata_i[i*DW +: DW]  = 32'hDEAD0000 | 32'(i);
                bus.out_error_i[i]           = 1'b1;
            end
        end
    endtask

    // Drive one request from a negedge in IDLE; returns one cycle after in_ready
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [SW-1:0] ws, input int slave, input int wait_cyc,
                           input logic [DW-1:0] srd, input logic serr, input bit never);
        obs_lat = 0; obs_vcycles = 0; obs_vmask = '0; obs_rdata = '0; obs_err = 1'b0;
        obs_fields_ok = 1'b1; obs_busy_ok = 1'b1; obs_pulse_ok = 1'b0;
        drive_slaves(slave, 1'b0, '0, 1'b0);
        bus.in_valid_i = 1'b1; bus.in_write_i = wr; bus.in_addr_i = addr;
        bus.in_wdata_i = wd;   bus.in_wstrb_i = ws;
        @(negedge clk);
        obs_lat = 1;
        bus.in_valid_i = 1'b0; bus.in_write_i = ~wr; bus.in_addr_i = ~addr;
        bus.in_wdata_i = ~wd;  bus.in_wstrb_i = ~ws;
        forever begin
            if (busy !== 1'b1) obs_busy_ok = 1'b0;
            if (bus.in_ready_o === 1'b1) begin
                obs_rdata = bus.in_rdata_o;
                obs_err   = bus.in_error_o;
                break;
            end
            if (bus.out_valid_o !== '0) begin
                obs_vcycles++;
                obs_vmask |= bus.out_valid_o;
                if (bus.out_write_o !== wr || bus.out_addr_o !== addr ||
                    bus.out_wdata_o !== wd || bus.out_wstrb_o !== ws)
                    obs_fields_ok = 1'b0;
            end
            drive_slaves(slave, bus.out_valid_o[slave] === 1'b1 && !never && obs_vcycles > wait_cyc,
                         srd, serr);
            @(negedge clk);
            obs_lat++;
            if (obs_lat > 2000) begin
                obs_lat = -1;
                break;
            end
        end
        bus.out_ready_i = '0;
        @(negedge clk);
        obs_pulse_ok = (bus.in_ready_o === 1'b0) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.out_valid_o !== '0 || bus.in_ready_o !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid=%b ready=%b busy=%b, required 0000 0 0",
                     bus.out_valid_o, bus.in_ready_o, busy);
        end
        n_tests++;
        if (ec !== 16'd0 || lea !== '0 || bus.in_rdata_o !== '0 || bus.out_addr_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data: ec=%0d lea=%h rdata=%h oaddr=%h, required all zero",
                     ec, lea, bus.in_rdata_o, bus.out_addr_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_hit();
        exp_t e;
        sb.push_back('{lat: 2, vmask: 4'b0010, vcycles: 1, rdata: 32'hCAFEF00D, err: 1'b0});
        run_txn(1'b0, 64'h12004, 32'h0, 4'h0, 1, 0, 32'hCAFEF00D, 1'b0, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (obs_lat !== e.lat || obs_vmask !== e.vmask || obs_vcycles !== e.vcycles) begin
            n_fail++;
            $display("FAIL read_hit timing: lat=%0d vmask=%b vcyc=%0d, required %0d %b %0d",
                     obs_lat, obs_vmask, obs_vcycles, e.lat, e.vmask, e.vcycles);
        end
        n_tests++;
        if (obs_rdata !== e.rdata || obs_err !== e.err || !(obs_fields_ok && obs_busy_ok && obs_pulse_ok)) begin
            n_fail++;
            $display("FAIL read_hit resp: rdata=%h err=%b flags=%b%b%b, required %h %b 111",
                     obs_rdata, obs_err, obs_fields_ok, obs_busy_ok, obs_pulse_ok, e.rdata, e.err);
        end
    endtask

    task automatic test_write_wait();
        exp_t e;
        sb.push_back('{lat: 5, vmask: 4'b1000, vcycles: 4, rdata: 32'h0, err: 1'b0});
        run_txn(1'b1, 64'h14010, 32'hA5, 4'h1, 3, 3, 32'h0, 1'b0, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (obs_lat !== e.lat || obs_vmask !== e.vmask || obs_vcycles !== e.vcycles) begin
            n_fail++;
            $display("FAIL write_wait timing: lat=%0d vmask=%b vcyc=%0d, required %0d %b %0d",
                     obs_lat, obs_vmask, obs_vcycles, e.lat, e.vmask, e.vcycles);
        end
        n_tests++;
        if (obs_rdata !== e.rdata || obs_err !== e.err || !(obs_fields_ok && obs_busy_ok && obs_pulse_ok)) begin
            n_fail++;
            $display("FAIL write_wait resp: rdata=%h err=%b flags=%b%b%b, required %h %b 111",
                     obs_rdata, obs_err, obs_fields_ok, obs_busy_ok, obs_pulse_ok, e.rdata, e.err);
        end
    endtask

    task automatic test_slave_error();
        exp_t e;
        sb.push_back('{lat: 3, vmask: 4'b0001, vcycles: 2, rdata: 32'h12345678, err: 1'b1});
        run_txn(1'b0, 64'h11008, 32'h0, 4'h0, 0, 1, 32'h12345678, 1'b1, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (obs_lat !== e.lat || obs_vmask !== e.vmask || obs_rdata !== e.rdata || obs_err !== e.err) begin
            n_fail++;
            $display("FAIL slave_error: lat=%0d vmask=%b rdata=%h err=%b, required %0d %b %h %b",
                     obs_lat, obs_vmask, obs_rdata, obs_err, e.lat, e.vmask, e.rdata, e.err);
        end
        n_tests++;
        if (ec !== 16'(exp_errs)) begin
            n_fail++;
            $display("FAIL slave_error count: ec=%0d, required %0d", ec, exp_errs);
        end
    endtask

    task automatic test_decode_error();
        exp_t e;
        sb.push_back('{lat: 2, vmask: 4'b0000, vcycles: 0, rdata: BAD, err: 1'b1});
        exp_errs++;
        run_txn(1'b0, 64'h20000, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0, 1'b1);
        e = sb.pop_front();
        n_tests++;
        if (obs_lat !== e.lat || obs_vmask !== e.vmask || obs_rdata !== e.rdata || obs_err !== e.err) begin
            n_fail++;
            $display("FAIL decode_error: lat=%0d vmask=%b rdata=%h err=%b, required %0d %b %h %b",
                     obs_lat, obs_vmask, obs_rdata, obs_err, e.lat, e.vmask, e.rdata, e.err);
        end
        n_tests++;
        if (ec !== 16'(exp_errs) || lea !== 64'h20000) begin
            n_fail++;
            $display("FAIL decode_error regs: ec=%0d lea=%h, required %0d 20000", ec, lea, exp_errs);
        end
    endtask

    task automatic test_boundaries();
        logic [AW-1:0] addrs [7];
        int            slv [7];
        exp_t          e;
        logic [DW-1:0] rd;
        addrs = '{64'h11000, 64'h11FFC, 64'h12000, 64'h13000, 64'h14FFC, 64'h10FFC, 64'h15000};
        slv   = '{0, 0, 1, 2, 3, -1, -1};
        for (int k = 0; k < 7; k++) begin
            rd = 32'hB0000000 | addrs[k][31:0];
            if (slv[k] < 0) begin
                sb.push_back('{lat: 2, vmask: 4'b0000, vcycles: 0, rdata: BAD, err: 1'b1});
                exp_errs++;
                run_txn(1'b0, addrs[k], 32'h0, 4'h0, 0, 0, rd, 1'b0, 1'b1);
            end else begin
                sb.push_back('{lat: 2, vmask: 4'b0001 << slv[k], vcycles: 1, rdata: rd, err: 1'b0});
                run_txn(1'b0, addrs[k], 32'h0, 4'h0, slv[k], 0, rd, 1'b0, 1'b0);
            end
            e = sb.pop_front();
            n_tests++;
            if (obs_lat !== e.lat || obs_vmask !== e.vmask || obs_rdata !== e.rdata || obs_err !== e.err) begin
                n_fail++;
                $display("FAIL boundary %h: lat=%0d vmask=%b rdata=%h err=%b, required %0d %b %h %b",
                         addrs[k], obs_lat, obs_vmask, obs_rdata, obs_err, e.lat, e.vmask, e.rdata, e.err);
            end
        end
        n_tests++;
        if (ec !== 16'(exp_errs) || lea !== 64'h15000) begin
            n_fail++;
            $display("FAIL boundary regs: ec=%0d lea=%h, required %0d 15000", ec, lea, exp_errs);
        end
    endtask

`ifdef PERIPH_REG_DEMUX_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        sb.push_back('{lat: 9, vmask: 4'b0001, vcycles: 8, rdata: BAD, err: 1'b1});
        exp_errs++;
        run_txn(1'b0, 64'h11100, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0, 1'b1);
        e = sb.pop_front();
        n_tests++;
        if (obs_lat !== e.lat || obs_vcycles !== e.vcycles || obs_rdata !== e.rdata || obs_err !== e.err) begin
            n_fail++;
            $display("FAIL timeout: lat=%0d vcyc=%0d rdata=%h err=%b, required %0d %0d %h %b",
                     obs_lat, obs_vcycles, obs_rdata, obs_err, e.lat, e.vcycles, e.rdata, e.err);
        end
        n_tests++;
        if (ec !== 16'(exp_errs) || lea !== 64'h11100) begin
            n_fail++;
            $display("FAIL timeout regs: ec=%0d lea=%h, required %0d 11100", ec, lea, exp_errs);
        end
        sb.push_back('{lat: 9, vmask: 4'b0001, vcycles: 8, rdata: 32'h5EC0DA7A, err: 1'b0});
        run_txn(1'b0, 64'h11200, 32'h0, 4'h0, 0, 7, 32'h5EC0DA7A, 1'b0, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (obs_lat !== e.lat || obs_vcycles !== e.vcycles || obs_rdata !== e.rdata ||
            obs_err !== e.err || ec !== 16'(exp_errs)) begin
            n_fail++;
            $display("FAIL timeout_last_ready: lat=%0d vcyc=%0d rdata=%h err=%b ec=%0d, required %0d %0d %h %b %0d",
                     obs_lat, obs_vcycles, obs_rdata, obs_err, ec, e.lat, e.vcycles, e.rdata, e.err, exp_errs);
        end
    endtask
`endif

    task automatic test_back_to_back();
        exp_t          e;
        int            s;
        int            w;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        logic [SW-1:0] ws;
        logic          wr;
        logic          se;
        for (int k = 0; k < 12; k++) begin
            s  = int'($urandom_range(3, 0));
            w  = int'($urandom_range(3, 0));
            a  = 64'h11000 + 64'(s) * 64'h1000 + 64'($urandom_range(1023, 0)) * 64'd4;
            wd = $urandom;
            rd = $urandom;
            ws = 4'($urandom);
            wr = 1'($urandom);
            se = 1'($urandom);
            sb.push_back('{lat: w + 2, vmask: 4'b0001 << s, vcycles: w + 1, rdata: rd, err: se});
            run_txn(wr, a, wd, ws, s, w, rd, se, 1'b0);
            e = sb.pop_front();
            n_tests++;
            if (obs_lat !== e.lat || obs_vmask !== e.vmask || obs_vcycles !== e.vcycles ||
                obs_rdata !== e.rdata || obs_err !== e.err ||
                !(obs_fields_ok && obs_busy_ok && obs_pulse_ok)) begin
                n_fail++;
                $display("FAIL b2b[%0d] %h: lat=%0d vmask=%b vcyc=%0d rdata=%h err=%b flags=%b%b%b, required %0d %b %0d %h %b 111",
                         k, a, obs_lat, obs_vmask, obs_vcycles, obs_rdata, obs_err,
                         obs_fields_ok, obs_busy_ok, obs_pulse_ok,
                         e.lat, e.vmask, e.vcycles, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_overlap();
        exp_t e;
        sb.push_back('{lat: 2, vmask: 4'b0001, vcycles: 1, rdata: 32'h00005A5A, err: 1'b0});
        bus2.in_valid_i = 1'b1; bus2.in_addr_i = 64'h12000; bus2.in_write_i = 1'b0;
        @(negedge clk);
        bus2.in_valid_i = 1'b0;
        obs_vmask = bus2.out_valid_o;
        bus2.out_ready_i = 4'b0011;
        bus2.out_rdata_i = {32'h0, 32'h0, 32'h11111111, 32'h00005A5A};
        @(negedge clk);
        obs_rdata = bus2.in_rdata_o;
        obs_err   = bus2.in_error_o;
        e = sb.pop_front();
        n_tests++;
        if (obs_vmask !== e.vmask || bus2.in_ready_o !== 1'b1 || obs_rdata !== e.rdata || obs_err !== e.err) begin
            n_fail++;
            $display("FAIL overlap: vmask=%b ready=%b rdata=%h err=%b, required %b 1 %h %b",
                     obs_vmask, bus2.in_ready_o, obs_rdata, obs_err, e.vmask, e.rdata, e.err);
        end
        bus2.out_ready_i = '0;
        @(negedge clk);
        sb.push_back('{lat: 2, vmask: 4'b0000, vcycles: 0, rdata: BAD, err: 1'b1});
        bus2.in_valid_i = 1'b1; bus2.in_addr_i = 64'h30000;
        @(negedge clk);
        bus2.in_valid_i = 1'b0;
        obs_vmask = bus2.out_valid_o;
        @(negedge clk);
        e = sb.pop_front();
        n_tests++;
        if (obs_vmask !== e.vmask || bus2.in_ready_o !== 1'b1 || bus2.in_rdata_o !== e.rdata ||
            bus2.in_error_o !== e.err || ec2 !== 16'd1 || lea2 !== 64'h30000) begin
            n_fail++;
            $display("FAIL disabled_rule: vmask=%b ready=%b rdata=%h err=%b ec=%0d lea=%h, required %b 1 %h %b 1 30000",
                     obs_vmask, bus2.in_ready_o, bus2.in_rdata_o, bus2.in_error_o, ec2, lea2,
                     e.vmask, e.rdata, e.err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   wait_n;
`ifdef PERIPH_REG_DEMUX_TIMEOUT_EN
        wait_n = 3;
`else
        wait_n = 300;
`endif
        drive_slaves(2, 1'b0, '0, 1'b0);
        bus.in_valid_i = 1'b1; bus.in_write_i = 1'b0; bus.in_addr_i = 64'h13040;
        bus.in_wdata_i = '0;   bus.in_wstrb_i = '0;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        repeat (wait_n) @(negedge clk);
        n_tests++;
        if (bus.out_valid_o !== 4'b0100 || busy !== 1'b1 || ec !== 16'(exp_errs)) begin
            n_fail++;
            $display("FAIL fwd_hold: valid=%b busy=%b ec=%0d, required 0100 1 %0d",
                     bus.out_valid_o, busy, ec, exp_errs);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_errs = 0;
        n_tests++;
        if (bus.out_valid_o !== '0 || busy !== 1'b0 || ec !== 16'd0 || lea !== '0 || bus.in_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b busy=%b ec=%0d lea=%h ready=%b, required 0000 0 0 0 0",
                     bus.out_valid_o, busy, ec, lea, bus.in_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb.push_back('{lat: 3, vmask: 4'b0100, vcycles: 2, rdata: 32'h600DCAFE, err: 1'b0});
        run_txn(1'b0, 64'h13040, 32'h0, 4'h0, 2, 1, 32'h600DCAFE, 1'b0, 1'b0);
        e = sb.pop_front();
        n_tests++;
        if (obs_lat !== e.lat || obs_vmask !== e.vmask || obs_rdata !== e.rdata ||
            obs_err !== e.err || !obs_pulse_ok) begin
            n_fail++;
            $display("FAIL after_reset: lat=%0d vmask=%b rdata=%h err=%b pulse=%b, required %0d %b %h %b 1",
                     obs_lat, obs_vmask, obs_rdata, obs_err, obs_pulse_ok, e.lat, e.vmask, e.rdata, e.err);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        bus.in_valid_i  = 1'b0; bus.in_write_i = 1'b0; bus.in_addr_i = '0;
        bus.in_wdata_i  = '0;   bus.in_wstrb_i = '0;
        bus.out_ready_i = '0;   bus.out_rdata_i = '0;  bus.out_error_i = '0;
        bus2.in_valid_i  = 1'b0; bus2.in_write_i = 1'b0; bus2.in_addr_i = '0;
        bus2.in_wdata_i  = '0;   bus2.in_wstrb_i = '0;
        bus2.out_ready_i = '0;   bus2.out_rdata_i = '0;  bus2.out_error_i = '0;

        test_reset();
        test_read_hit();
        test_write_wait();
        test_slave_error();
        test_decode_error();
        test_boundaries();
`ifdef PERIPH_REG_DEMUX_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        test_overlap();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
